// File: rtl/ga_pkg.sv
// ga_pkg: shared definitions for the Gate Array palette/config register stage.
//   - command codes carried in cpu_data[7:6] of a Gate Array I/O write
//   - reset defaults for inks, border and screen mode
//   - ink_t: 5-bit hardware colour
package ga_pkg;

  typedef logic [4:0] ink_t;

  localparam logic [1:0] CMD_SELECT = 2'b00;
  localparam logic [1:0] CMD_INK    = 2'b01;
  localparam logic [1:0] CMD_CONFIG = 2'b10;
  localparam logic [1:0] CMD_RAM    = 2'b11;

  localparam ink_t       RESET_INK_DEFAULT  = 5'h14;
  localparam logic [1:0] RESET_MODE_DEFAULT = 2'd1;

endpackage

// File: rtl/ga_edge.sv
// ga_edge: single-bit edge detector.
//   clk     in  system clock
//   n_reset in  asynchronous active-low reset
//   d       in  input level (already in the clk domain)
//   pulse   out one-cycle pulse on the selected edge of d
// RISING=1 detects 0->1, RISING=0 detects 1->0. RESET_VAL is the assumed
// history value after reset, so no spurious edge is seen when reset releases
// while d sits at its idle level.
module ga_edge #(
  parameter logic RISING    = 1'b1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic pulse
);

  logic d_q_r;

  // One-cycle history of the input level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      d_q_r <= RESET_VAL;
    end else begin
      d_q_r <= d;
    end
  end

  assign pulse = RISING ? (d & ~d_q_r) : (d_q_r & ~d);

endmodule

// File: rtl/ga_palette.sv
// ga_palette: Gate Array register stage feeding the video block.
//   clk          in  pixel clock
//   n_reset      in  asynchronous active-low reset
//   io_wr        in  CPU I/O write request (may be held several cycles)
//   cpu_addr     in  CPU address; Gate Array selected by A15=0, A14=1
//   cpu_data     in  CPU write data; [7:6] is the command
//   vga_hs       in  active-low horizontal sync from the video block
//   pen          in  current pixel pen
//   color        out hardware colour of ink[pen] (combinational, zero latency)
//   border_color out border hardware colour
//   mode         out active screen mode (changes only at sync start)
//   lower_rom_en out lower ROM mapped
//   upper_rom_en out upper ROM mapped
//   ram_config   out RAM bank configuration
//   int_clear    out one-cycle pulse clearing the video interrupt counter
module ga_palette
  import ga_pkg::*;
#(
  parameter ink_t       RESET_INK  = RESET_INK_DEFAULT,
  parameter logic [1:0] RESET_MODE = RESET_MODE_DEFAULT
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        io_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        vga_hs,
  input  logic [3:0]  pen,
  output logic [4:0]  color,
  output logic [4:0]  border_color,
  output logic [1:0]  mode,
  output logic        lower_rom_en,
  output logic        upper_rom_en,
  output logic [2:0]  ram_config,
  output logic        int_clear
);

  logic       io_wr_rise_s;
  logic       hs_start_s;
  logic       wr_fire_s;
  logic [1:0] cmd_s;

  ink_t       ink_r [16];
  ink_t       border_r;
  logic [3:0] sel_pen_r;
  logic       border_sel_r;
  logic [1:0] pending_mode_r;
  logic [1:0] mode_r;
  logic       lower_rom_en_r;
  logic       upper_rom_en_r;
  logic [2:0] ram_config_r;
  logic       int_clear_r;
  // High in the cycle a config write becomes visible; blocks the mode latch
  // from picking up a value that landed on the same cycle as sync start.
  logic       mode_wr_fresh_r;

  ga_edge #(.RISING(1'b1), .RESET_VAL(1'b0)) u_wr_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (io_wr),
    .pulse   (io_wr_rise_s)
  );

  ga_edge #(.RISING(1'b0), .RESET_VAL(1'b1)) u_hs_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (vga_hs),
    .pulse   (hs_start_s)
  );

  assign wr_fire_s = io_wr_rise_s & ~cpu_addr[15] & cpu_addr[14];
  assign cmd_s     = cpu_data[7:6];

  // Decode Gate Array writes into the ink table, selection and config registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) begin
        ink_r[i] <= RESET_INK;
      end
      border_r        <= RESET_INK;
      sel_pen_r       <= 4'd0;
      border_sel_r    <= 1'b0;
      pending_mode_r  <= RESET_MODE;
      lower_rom_en_r  <= 1'b1;
      upper_rom_en_r  <= 1'b1;
      ram_config_r    <= 3'd0;
      int_clear_r     <= 1'b0;
      mode_wr_fresh_r <= 1'b0;
    end else begin
      int_clear_r     <= 1'b0;
      mode_wr_fresh_r <= 1'b0;
      if (wr_fire_s) begin
        case (cmd_s)
          CMD_SELECT: begin
            border_sel_r <= cpu_data[4];
            sel_pen_r    <= cpu_data[3:0];
          end
          CMD_INK: begin
            if (border_sel_r) begin
              border_r <= cpu_data[4:0];
            end else begin
              ink_r[sel_pen_r] <= cpu_data[4:0];
            end
          end
          CMD_CONFIG: begin
            pending_mode_r  <= cpu_data[1:0];
            lower_rom_en_r  <= ~cpu_data[2];
            upper_rom_en_r  <= ~cpu_data[3];
            int_clear_r     <= cpu_data[4];
            mode_wr_fresh_r <= 1'b1;
          end
          CMD_RAM: begin
            ram_config_r <= cpu_data[2:0];
          end
          default: begin
            ram_config_r <= ram_config_r;
          end
        endcase
      end
    end
  end

  // Screen mode only changes at the start of horizontal sync.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_r <= RESET_MODE;
    end else if (hs_start_s && !mode_wr_fresh_r) begin
      mode_r <= pending_mode_r;
    end else begin
      mode_r <= mode_r;
    end
  end

  // Pen lookup stays combinational: a register here would shift the picture by a pixel.
  assign color        = ink_r[pen];
  assign border_color = border_r;
  assign mode         = mode_r;
  assign lower_rom_en = lower_rom_en_r;
  assign upper_rom_en = upper_rom_en_r;
  assign ram_config   = ram_config_r;
  assign int_clear    = int_clear_r;

endmodule

// File: doc/ga_palette.md
Name: ga_palette

Overview:
- Gate Array register stage that sits directly upstream of the video block and feeds it `color`, `border_color`, `mode` and `int_clear`.
- It decodes CPU I/O writes to the Gate Array (A15=0, A14=1) and holds the 16-entry ink table, the border ink and the pen selection. It also holds the screen mode, ROM enables and RAM banking.
- It resolves the video block's 4-bit pen into a 5-bit hardware colour.
- Mode changes are deferred to the start of the next horizontal sync, matching CPC behaviour.

Parameters:
- RESET_INK, 5'h14, hardware colour loaded into all inks and the border on reset (palette index 20 = black).
- RESET_MODE, 2'd1, screen mode after reset.

Ports:
- clk  in  1  system clock (video pixel clock domain).
- n_reset  in  1  reset; asynchronous, active-low.
- io_wr  in  1  CPU I/O write request, active-high; may be held for several cycles.
- cpu_addr  in  16  CPU address during an I/O cycle.
- cpu_data  in  8  CPU write data.
- vga_hs  in  1  horizontal sync from the video block, active-low.
- pen  in  4  current pixel pen from the video block.
- color  out  5  hardware colour for the current pen.
- border_color  out  5  border hardware colour.
- mode  out  2  active screen mode.
- lower_rom_en  out  1  lower ROM mapped.
- upper_rom_en  out  1  upper ROM mapped.
- ram_config  out  3  RAM bank configuration (6128 banking).
- int_clear  out  1  one-cycle pulse that clears the video interrupt counter.

Behaviour:
- **Reset.** While n_reset=0, asynchronously:
  - all inks = RESET_INK; border = RESET_INK
  - selected pen = 0; border_sel = 0
  - mode = pending_mode = RESET_MODE
  - lower_rom_en = 1; upper_rom_en = 1
  - ram_config = 0; int_clear = 0
  - io_wr edge register = 0; vga_hs history = 1
  
  A reset asserted mid-write discards that write.
- **Write detect.** `wr_fire = io_wr & ~io_wr_q & ~cpu_addr[15] & cpu_addr[14]`.
  - Exactly one register update per io_wr assertion, however long it is held.
  - cpu_addr and cpu_data are sampled on the wr_fire cycle.
  - Register updates are visible on the cycle after wr_fire.
- **Command decode** on cpu_data[7:6]:
  - 00 select: border_sel <= cpu_data[4]; sel_pen <= cpu_data[3:0].
  - 01 ink: if border_sel, border <= cpu_data[4:0]; else ink[sel_pen] <= cpu_data[4:0].
  - 10 config:
    - pending_mode <= cpu_data[1:0]
    - lower_rom_en <= ~cpu_data[2]
    - upper_rom_en <= ~cpu_data[3]
    - if cpu_data[4]: int_clear = 1 for exactly one cycle (the cycle after wr_fire), then 0.
  - 11 RAM: ram_config <= cpu_data[2:0]; cpu_data[5:3] ignored.
- **Mode latch.**
  - `hs_start = vga_hs_q & ~vga_hs` (falling edge of active-low sync).
  - On hs_start, mode <= pending_mode.
  - A mode write whose update lands on the same cycle as hs_start is not taken at that edge; it applies at the next hs_start.
  - ROM and RAM enables take effect immediately, not gated by sync.
- **Colour output.**
  - color = ink[pen] is a combinational read. Zero latency relative to pen is mandatory: registering it would shift the image by one pixel.
  - border_color is driven directly from the border register.
  - An ink written while that pen is displayed changes color on the cycle after wr_fire.
- **Other rules.**
  - sel_pen persists across any number of ink writes; successive 01 writes hit the same entry.
  - Writes with A14=0 or A15=1 are ignored entirely, including int_clear.

Decomposition:
- Package `ga_pkg`:
  - command codes CMD_SELECT=2'b00, CMD_INK=2'b01, CMD_CONFIG=2'b10, CMD_RAM=2'b11
  - RESET_INK_DEFAULT=5'h14, RESET_MODE_DEFAULT=2'd1
  - typedef ink_t = logic [4:0]
- Optional sub-module `ga_edge`: a single-bit rising/falling edge detector with asynchronous active-low reset, instantiated for io_wr (rising) and vga_hs (falling). Everything else stays in `ga_palette`.

Test Plan:
- **Reset defaults.** Pulse n_reset low, release; sweep pen 0..15 -> color=5'h14 for every pen, border_color=5'h14, mode=1, lower_rom_en=1, upper_rom_en=1, ram_config=0, int_clear=0.
- **Ink write.** Write 8'h03 then 8'h4B at addr 16'h7F00; hold io_wr 4 cycles each -> ink[3]=5'h0B one cycle after the second edge, other inks unchanged, only one update per write. Then write 8'h10 then 8'h44 -> border_color=5'h04, ink[3] still 5'h0B.
- **Deferred mode.** With vga_hs=1, write 8'h82 -> mode stays 1, lower_rom_en=1 immediately. On vga_hs 1->0, mode=2 on the next cycle. Write 8'h8E -> lower_rom_en=0, upper_rom_en=0.
- **Mode/sync collision.** Time a write of 8'h80 so its update cycle equals the hs_start cycle -> mode unchanged at that edge, becomes 0 at the following hs_start.
- **Interrupt clear.** Write 8'h91 -> int_clear high for exactly 1 cycle, pending_mode=1, lower_rom_en=1. Write 8'h91 at addr 16'hBF00 -> no pulse, no register change.
- **RAM banking and async reset.** Write 8'hC7 -> ram_config=3'b111. Assert n_reset mid-way through a held io_wr carrying 8'h4F -> all outputs return to defaults asynchronously, before the next clk edge, and no ink changes after release.
